// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed BCD scan controller for an N-digit 7-segment display.
// Optional build macro SEG_SCAN_ZERO_BLANK_EN: blank leading zeros at commit.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] iVAL,
  input  logic                  iLOAD,
  output logic                  oPEND,
  output logic [3:0]            oDEC,
  output logic [N_DIGITS-1:0]   oDIG,
  output logic                  oFRAME
);

  localparam int unsigned VAL_W   = 4 * N_DIGITS;
  localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIG_OFF    = {N_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [VAL_W-1:0]    VAL_DARK   = {VAL_W{1'b1}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic                  frame_q, frame_d;
  logic [3:0]            dec_q, dec_d;
  logic [N_DIGITS-1:0]   dig_q, dig_d;
  logic [N_DIGITS-1:0]   sel_c;

`ifdef SEG_SCAN_ZERO_BLANK_EN
  // Leading zeros from the top digit down become dark; digit 0 always shows.
  function automatic logic [VAL_W-1:0] blank_lead(input logic [VAL_W-1:0] v);
    logic lead;
    blank_lead = v;
    lead       = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      if (lead && (v[i*4 +: 4] == 4'h0)) begin
        blank_lead[i*4 +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction
`endif

  // Next-state, commit/load handling and registered output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    frame_d = 1'b0;
    dec_d   = 4'hF;
    sel_c   = '0;

    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (pflag_q) begin
`ifdef SEG_SCAN_ZERO_BLANK_EN
              disp_d = blank_lead(pend_q);
`else
              disp_d = pend_q;
`endif
              pflag_d = 1'b0;
              frame_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // A load on the commit edge lands after the old value has been taken
    if (iLOAD) begin
      pend_d  = iVAL;
      pflag_d = 1'b1;
    end

    if (state_d == ST_SHOW) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        if (idx_d == IDX_W'(i)) begin
          dec_d    = disp_d[i*4 +: 4];
          sel_c[i] = 1'b1;
        end
      end
    end
    dig_d = DIG_ACTIVE_LOW ? ~sel_c : sel_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= VAL_DARK;
      pend_q  <= VAL_DARK;
      pflag_q <= 1'b0;
      frame_q <= 1'b0;
      dec_q   <= 4'hF;
      dig_q   <= DIG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      frame_q <= frame_d;
      dec_q   <= dec_d;
      dig_q   <= dig_d;
    end
  end

  assign oPEND  = pflag_q;
  assign oDEC   = dec_q;
  assign oDIG   = dig_q;
  assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 4-cycle SHOW, 1-cycle BLANK, active-low select.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] iVAL;
  logic        iLOAD;
  logic        oPEND;
  logic [3:0]  oDEC;
  logic [3:0]  oDIG;
  logic        oFRAME;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_pend;

  seg_scan_ctrl #(
    .N_DIGITS      (4),
    .SCAN_DIV      (4),
    .BLANK_CYC     (1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .iVAL  (iVAL),
    .iLOAD (iLOAD),
    .oPEND (oPEND),
    .oDEC  (oDEC),
    .oDIG  (oDIG),
    .oFRAME(oFRAME)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame from its leading BLANK of digit 0; loads applied before edge s.
  task automatic run_frame(input string tag, input logic [15:0] disp, input bit frame0,
                           input int ld1, input logic [15:0] v1,
                           input int ld2, input logic [15:0] v2);
    int s;
    logic [3:0] exp_dig;
    logic [3:0] exp_dec;
    s = 0;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 5; k++) begin
        if (k == 0) begin
          exp_dig = 4'hF;
          exp_dec = 4'hF;
        end else begin
          exp_dig = ~(4'b0001 << d);
          exp_dec = disp[d*4 +: 4];
        end
        chk($sformatf("%s dig s%0d", tag, s), 16'(oDIG), 16'(exp_dig));
        chk($sformatf("%s dec s%0d", tag, s), 16'(oDEC), 16'(exp_dec));
        chk($sformatf("%s frame s%0d", tag, s), 16'(oFRAME), (s == 0) ? 16'(frame0) : 16'h0);
        chk($sformatf("%s pend s%0d", tag, s), 16'(oPEND), 16'(exp_pend));
        if (s == ld1) begin
          iLOAD = 1'b1;
          iVAL  = v1;
        end else if (s == ld2) begin
          iLOAD = 1'b1;
          iVAL  = v2;
        end else begin
          iLOAD = 1'b0;
        end
        step();
        if (iLOAD) exp_pend = 1'b1;
        else if (s == 19) exp_pend = 1'b0;
        s++;
      end
    end
    iLOAD = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    iVAL     = 16'h0;
    iLOAD    = 1'b0;
    exp_pend = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst dig", 16'(oDIG), 16'h000F);
    chk("rst dec", 16'(oDEC), 16'h000F);
    chk("rst pend", 16'(oPEND), 16'h0);
    chk("rst frame", 16'(oFRAME), 16'h0);
    rst = 1'b1;

    // Dark scan, no loads
    run_frame("t1", 16'hFFFF, 1'b0, -1, 16'h0, -1, 16'h0);
    // Load mid-frame, commits at the wrap
    run_frame("t2a", 16'hFFFF, 1'b0, 7, 16'h1234, -1, 16'h0);
    run_frame("t2b", 16'h1234, 1'b1, -1, 16'h0, -1, 16'h0);
    // Two loads in one frame: last wins, single pulse
    run_frame("t3a", 16'h1234, 1'b0, 3, 16'h1111, 12, 16'h2222);
    run_frame("t3b", 16'h2222, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame("t3c", 16'h2222, 1'b0, -1, 16'h0, -1, 16'h0);
    // Load on the wrap edge while another value is pending
    run_frame("t4a", 16'h2222, 1'b0, 5, 16'h1234, 19, 16'h5678);
    run_frame("t4b", 16'h1234, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame("t4c", 16'h5678, 1'b1, -1, 16'h0, -1, 16'h0);
    // Reset during SHOW of digit 2 with a load still pending
    run_frame("t5a", 16'h5678, 1'b0, 2, 16'h9876, -1, 16'h0);
    chk("t5 frame", 16'(oFRAME), 16'h1);
    iLOAD = 1'b1;
    iVAL  = 16'h4321;
    step();
    iLOAD = 1'b0;
    repeat (11) step();
    chk("t5 show2 dig", 16'(oDIG), 16'h000B);
    chk("t5 show2 dec", 16'(oDEC), 16'h0008);
    chk("t5 show2 pend", 16'(oPEND), 16'h1);
    rst = 1'b0;
    #1;
    chk("t5 rst dig", 16'(oDIG), 16'h000F);
    chk("t5 rst dec", 16'(oDEC), 16'h000F);
    chk("t5 rst pend", 16'(oPEND), 16'h0);
    @(negedge clk);
    rst      = 1'b1;
    exp_pend = 1'b0;
    run_frame("t5b", 16'hFFFF, 1'b0, -1, 16'h0, -1, 16'h0);
    // Leading-zero value, blanked only in the zero-blank build
    run_frame("t6a", 16'hFFFF, 1'b0, 0, 16'h0040, -1, 16'h0);
`ifdef SEG_SCAN_ZERO_BLANK_EN
    run_frame("t6b", 16'hFF40, 1'b1, -1, 16'h0, -1, 16'h0);
`else
    run_frame("t6b", 16'h0040, 1'b1, -1, 16'h0, -1, 16'h0);
`endif
    chk("end frame", 16'(oFRAME), 16'h0);
    chk("end pend", 16'(oPEND), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
